// File: rtl/score_timer_bcd.sv
// rtl/score_timer_bcd.sv - whack-a-mole scoreboard: 4-digit BCD score, 2-digit BCD countdown, run/over FSM
module score_timer_bcd #(
  parameter int         TICK_DIV  = 100_000_000,
  parameter int         GAME_SECS = 60,
  parameter logic [3:0] BLANK     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] display7,
  output logic [3:0] display6,
  output logic [3:0] display5,
  output logic [3:0] display4,
  output logic [3:0] display3,
  output logic [3:0] display2,
  output logic [3:0] display1,
  output logic [3:0] display0,
  output logic       running,
  output logic       game_over
);

  // Prescaler width; TICK_DIV >= 2 so at least one bit is needed.
  localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);

  // Game length split into BCD digits at elaboration time.
  localparam logic [3:0] GAME_TENS  = 4'(GAME_SECS / 10);
  localparam logic [3:0] GAME_UNITS = 4'(GAME_SECS % 10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              enter_run;
  logic              tick;
  logic              timer_last;

  logic [PW-1:0]     presc_q;
  logic [3:0]        timer_tens_q;
  logic [3:0]        timer_units_q;

  // score_q[3] is the thousands digit, score_q[0] the units digit.
  logic [3:0][3:0]   score_q;
  logic [3:0][3:0]   score_inc;
  logic [3:0][3:0]   score_dec;
  logic              inc_carry;
  logic              dec_borrow;
  logic              score_max;
  logic              score_zero;

  logic              running_q;
  logic              game_over_q;

  // One-second strobe and last-second detect; tick only exists while running.
  always_comb begin
    tick       = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    timer_last = (timer_tens_q == 4'd0) && (timer_units_q == 4'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enter_run marks the edge on which a fresh game is loaded.
  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        // start is deliberately ignored mid-game.
        if (tick && timer_last) begin
          state_d = S_OVER;
        end
      end
      S_OVER: begin
        if (start) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Prescaler: counts 0..TICK_DIV-1 in RUN only, cleared on game start.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else if (enter_run) begin
      presc_q <= '0;
    end else if (state_q == S_RUN) begin
      if (tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PRESC_ONE;
      end
    end
  end

  // Countdown timer with BCD borrow; the 01 -> 00 step coincides with entering OVER.
  always_ff @(posedge clk) begin
    if (rst || enter_run) begin
      timer_tens_q  <= GAME_TENS;
      timer_units_q <= GAME_UNITS;
    end else if (tick) begin
      if (timer_units_q == 4'd0) begin
        timer_units_q <= 4'd9;
        timer_tens_q  <= timer_tens_q - 4'd1;
      end else begin
        timer_units_q <= timer_units_q - 4'd1;
      end
    end
  end

  // BCD +1 and -1 of the score with digit-to-digit ripple.
  always_comb begin
    score_inc  = score_q;
    score_dec  = score_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (score_q[i] >= 4'd9) begin
          score_inc[i] = 4'd0;
        end else begin
          score_inc[i] = score_q[i] + 4'd1;
          inc_carry    = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (score_q[i] == 4'd0) begin
          score_dec[i] = 4'd9;
        end else begin
          score_dec[i] = score_q[i] - 4'd1;
          dec_borrow   = 1'b0;
        end
      end
    end
    score_max  = (score_q == 16'h9999);
    score_zero = (score_q == 16'h0000);
  end

  // Score register: moves only in RUN, saturates at 0000 and 9999, hit+miss cancel.
  always_ff @(posedge clk) begin
    if (rst || enter_run) begin
      score_q <= '0;
    end else if (state_q == S_RUN) begin
      if (hit && !miss && !score_max) begin
        score_q <= score_inc;
      end else if (miss && !hit && !score_zero) begin
        score_q <= score_dec;
      end
    end
  end

  // Status flags registered from the next state so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      running_q   <= (state_d == S_RUN);
      game_over_q <= (state_d == S_OVER);
    end
  end

  // Digit mapping for the scanner: score on 7..4, blanks on 3..2, timer on 1..0.
  always_comb begin
    display7  = score_q[3];
    display6  = score_q[2];
    display5  = score_q[1];
    display4  = score_q[0];
    display3  = BLANK;
    display2  = BLANK;
    display1  = timer_tens_q;
    display0  = timer_units_q;
    running   = running_q;
    game_over = game_over_q;
  end

endmodule
